freq_meter_mc: RTL and testbench
================================

Name: freq_meter_mc

Overview:
- Parametrised multi-channel successor to the single-channel frequency and time-interval measurement blocks.
- Two modes per run:
  - Equal-precision frequency: the gate is aligned to signal edges; the block counts reference cycles, signal periods and high-time cycles.
  - Interval: counts reference cycles from a rising edge on channel A to the next rising edge on channel B.
- Sits between the input pins and the UART result framer.
- Results leave through a valid/ready handshake.

Parameters:
- N_CH, 4: number of input channels.
- CNT_W, 32: width of every result counter.
- GATE_CYC, 100000000: minimum gate length in clk cycles (1 s at 100 MHz).
- TIMEOUT_CYC, 200000000: maximum clk cycles spent waiting for any edge.
- SYNC_STAGES, 2: synchroniser flops per input, minimum 2.

Ports:
- clk, in, 1: measurement clock (100 MHz PLL output).
- rst_n, in, 1: synchronous, active-low reset.
- sig_in, in, N_CH: asynchronous measured signals.
- start, in, 1: one-cycle request; accepted only in IDLE.
- mode, in, 1: 0 = frequency, 1 = interval; sampled on start.
- ch_sel, in, max(1,$clog2(N_CH)): frequency channel / interval channel A; sampled on start.
- ch_sel_b, in, max(1,$clog2(N_CH)): interval channel B; sampled on start.
- busy, out, 1: high in every state except IDLE.
- res_valid, out, 1: result available.
- res_ready, in, 1: downstream accepts the result.
- res_cnt_ref, out, CNT_W: clk cycles in the window.
- res_cnt_sig, out, CNT_W: signal periods in the window (frequency mode); 0 in interval mode.
- res_cnt_high, out, CNT_W: clk cycles with the synced signal high (frequency mode); 0 in interval mode.
- res_ovf, out, 1: a counter saturated.
- res_timeout, out, 1: the run aborted on timeout.

Behaviour:
- Reset: the clk edge with rst_n=0 forces IDLE and clears all counters and outputs (busy, res_valid, all res_* = 0). This applies at any time, including mid-measurement and while res_valid is pending.
- Input conditioning:
  - Each sig_in bit passes through SYNC_STAGES flops plus one delay flop.
  - rise[i] = synced & ~delayed.
  - Pin-to-rise latency is SYNC_STAGES+1 cycles, identical on all channels.
- Selected channels (ch_sel, ch_sel_b, mode) are registered on start. Input changes during a run have no effect.
- State machine:
  - IDLE: start=1 → ARM. Counters are cleared on entry to ARM.
  - ARM: waits for rise[A] (A = ch_sel). The rise cycle is window cycle 0 → MEASURE. Timeout counter expires → DONE with timeout.
  - MEASURE, frequency mode:
    - Every cycle: cnt_ref+1, cnt_high+synced[A], cnt_sig+rise[A].
    - The close condition is evaluated first: if rise[A] and cnt_ref ≥ GATE_CYC, then cnt_sig+1, cnt_ref and cnt_high are not incremented, → DONE.
    - Result: cnt_ref = exact cycle distance between the opening and closing edges; cnt_sig = whole periods.
  - MEASURE, interval mode:
    - cnt_ref+1 per cycle until rise[B] → DONE.
    - cnt_ref = cycle distance A→B.
    - A B edge in the same cycle as the opening A edge is ignored; the block waits for the next B edge.
    - ch_sel_b = ch_sel measures one period.
  - DONE: res_* are loaded from the counters on entry; res_valid=1. Outputs are held stable until res_valid & res_ready → IDLE, res_valid=0 on the next cycle. start is ignored here.
- Timeout:
  - A separate counter is cleared on entry to ARM and on each accepted window edge.
  - It increments in ARM, and in MEASURE once cnt_ref ≥ GATE_CYC (frequency mode) or always (interval mode).
  - Reaching TIMEOUT_CYC → DONE with res_timeout=1; counters are reported as accumulated.
- Saturation: each counter holds at 2^CNT_W−1 and sets a sticky ovf flag, reported as res_ovf.
- busy rises the cycle after an accepted start.

Test Plan:
- Frequency measurement:
  - Stimulus: GATE_CYC=1000; ch2 square wave, period 10 cycles, 50 % duty; start with ch_sel=2.
  - Required: res_cnt_ref=1000, res_cnt_sig=100, res_cnt_high=500, ovf=0, timeout=0.
- Interval measurement:
  - Stimulus: mode=1, A=0, B=1; ch0 rises at T, ch1 rises at T+37.
  - Required: res_cnt_ref=37, res_cnt_sig=0.
  - Repeat with ch1 also rising at T and again at T+50 → res_cnt_ref=50.
- Handshake:
  - Stimulus: hold res_ready=0 for 20 cycles while toggling sig_in and pulsing start.
  - Required: res_* and res_valid remain stable; start is ignored.
  - Then res_ready=1 for one cycle → res_valid=0 and busy=0 on the next cycle; a new start is accepted.
- Timeout:
  - Stimulus: TIMEOUT_CYC=500; selected channel held at constant 0.
  - Required: exactly 500 cycles after entering ARM, res_valid=1 with res_timeout=1 and res_cnt_ref=0.
- Saturation:
  - Stimulus: CNT_W=8, GATE_CYC=300, period 20.
  - Required: res_cnt_ref=255, res_ovf=1, and res_cnt_sig=15 at close (cycle 300).
- Reset mid-run:
  - Stimulus: rst_n=0 for one cycle during MEASURE.
  - Required: next cycle busy=0, res_valid=0, all res_*=0; a subsequent run gives results identical to a fresh run.

Source files
------------

// File: rtl/freq_meter_mc.sv
// Multi-channel equal-precision frequency / A-to-B interval meter.
// Edge-aligned gate, saturating counters, timeout abort, valid/ready result port.
module freq_meter_mc #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_CYC    = 100000000,
    parameter int TIMEOUT_CYC = 200000000,
    parameter int SYNC_STAGES = 2,
    localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  sig_in,
    input  logic             start,
    input  logic             mode,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic [SEL_W-1:0] ch_sel_b,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_cnt_ref,
    output logic [CNT_W-1:0] res_cnt_sig,
    output logic [CNT_W-1:0] res_cnt_high,
    output logic             res_ovf,
    output logic             res_timeout
);

    localparam int GW = $clog2(GATE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [GW-1:0]    GATE_LIM = GW'(GATE_CYC);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

    logic [N_CH-1:0] synced;
    logic [N_CH-1:0] delayed_reg;
    logic [N_CH-1:0] rise;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) chain_reg <= '0;
                else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], sig_in[gi]};
            end
            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) delayed_reg <= '0;
        else        delayed_reg <= synced;
    end
    assign rise = synced & ~delayed_reg;

    state_t             state_reg, state_next;
    logic               mode_reg, mode_next;
    logic [SEL_W-1:0]   ch_a_reg, ch_a_next, ch_b_reg, ch_b_next;
    logic [CNT_W-1:0]   cnt_ref_reg, cnt_ref_next;
    logic [CNT_W-1:0]   cnt_sig_reg, cnt_sig_next;
    logic [CNT_W-1:0]   cnt_high_reg, cnt_high_next;
    logic [GW-1:0]      gate_reg, gate_next;
    logic [TW-1:0]      to_reg, to_next;
    logic               ovf_reg, ovf_next;
    logic               res_valid_reg, res_valid_next;
    logic [CNT_W-1:0]   res_ref_reg, res_ref_next;
    logic [CNT_W-1:0]   res_sig_reg, res_sig_next;
    logic [CNT_W-1:0]   res_high_reg, res_high_next;
    logic               res_ovf_reg, res_ovf_next;
    logic               res_to_reg, res_to_next;

    logic synced_a, rise_a, rise_b, gate_reached;
    logic inc_ref, inc_high, inc_sig, inc_gate, inc_to, finish, timed_out;

    assign synced_a     = synced[ch_a_reg];
    assign rise_a       = rise[ch_a_reg];
    assign rise_b       = rise[ch_b_reg];
    // Gate length is tracked apart from cnt_ref so a saturated cnt_ref still closes on time.
    assign gate_reached = (gate_reg == GATE_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            mode_reg      <= 1'b0;
            ch_a_reg      <= '0;
            ch_b_reg      <= '0;
            cnt_ref_reg   <= '0;
            cnt_sig_reg   <= '0;
            cnt_high_reg  <= '0;
            gate_reg      <= '0;
            to_reg        <= '0;
            ovf_reg       <= 1'b0;
            res_valid_reg <= 1'b0;
            res_ref_reg   <= '0;
            res_sig_reg   <= '0;
            res_high_reg  <= '0;
            res_ovf_reg   <= 1'b0;
            res_to_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            ch_a_reg      <= ch_a_next;
            ch_b_reg      <= ch_b_next;
            cnt_ref_reg   <= cnt_ref_next;
            cnt_sig_reg   <= cnt_sig_next;
            cnt_high_reg  <= cnt_high_next;
            gate_reg      <= gate_next;
            to_reg        <= to_next;
            ovf_reg       <= ovf_next;
            res_valid_reg <= res_valid_next;
            res_ref_reg   <= res_ref_next;
            res_sig_reg   <= res_sig_next;
            res_high_reg  <= res_high_next;
            res_ovf_reg   <= res_ovf_next;
            res_to_reg    <= res_to_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        ch_a_next      = ch_a_reg;
        ch_b_next      = ch_b_reg;
        cnt_ref_next   = cnt_ref_reg;
        cnt_sig_next   = cnt_sig_reg;
        cnt_high_next  = cnt_high_reg;
        gate_next      = gate_reg;
        to_next        = to_reg;
        ovf_next       = ovf_reg;
        res_valid_next = res_valid_reg;
        res_ref_next   = res_ref_reg;
        res_sig_next   = res_sig_reg;
        res_high_next  = res_high_reg;
        res_ovf_next   = res_ovf_reg;
        res_to_next    = res_to_reg;
        inc_ref        = 1'b0;
        inc_high       = 1'b0;
        inc_sig        = 1'b0;
        inc_gate       = 1'b0;
        inc_to         = 1'b0;
        finish         = 1'b0;
        timed_out      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next    = S_ARM;
                    mode_next     = mode;
                    ch_a_next     = ch_sel;
                    ch_b_next     = ch_sel_b;
                    cnt_ref_next  = '0;
                    cnt_sig_next  = '0;
                    cnt_high_next = '0;
                    gate_next     = '0;
                    to_next       = '0;
                    ovf_next      = 1'b0;
                end
            end
            S_ARM: begin
                // The opening edge cycle is window cycle 0 and is counted.
                if (rise_a) begin
                    state_next = S_MEASURE;
                    inc_ref    = 1'b1;
                    inc_gate   = 1'b1;
                    inc_high   = ~mode_reg;
                    to_next    = '0;
                end else if (to_reg == TO_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    inc_to = 1'b1;
                end
            end
            S_MEASURE: begin
                if (!mode_reg) begin
                    if (rise_a && gate_reached) begin
                        inc_sig = 1'b1;
                        finish  = 1'b1;
                    end else begin
                        inc_ref  = 1'b1;
                        inc_gate = 1'b1;
                        inc_high = synced_a;
                        inc_sig  = rise_a;
                        inc_to   = gate_reached;
                    end
                end else begin
                    if (rise_b) begin
                        finish = 1'b1;
                    end else begin
                        inc_ref = 1'b1;
                        inc_to  = 1'b1;
                    end
                end
                if (inc_to && to_reg == TO_LAST) begin
                    inc_to    = 1'b0;
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_next     = S_IDLE;
                    res_valid_next = 1'b0;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (inc_ref) begin
            if (cnt_ref_reg == CNT_MAX) ovf_next = 1'b1;
            else                        cnt_ref_next = cnt_ref_reg + 1'b1;
        end
        if (inc_sig) begin
            if (cnt_sig_reg == CNT_MAX) ovf_next = 1'b1;
            else                        cnt_sig_next = cnt_sig_reg + 1'b1;
        end
        if (inc_high) begin
            if (cnt_high_reg == CNT_MAX) ovf_next = 1'b1;
            else                         cnt_high_next = cnt_high_reg + 1'b1;
        end
        if (inc_gate && !gate_reached) gate_next = gate_reg + 1'b1;
        if (inc_to)                    to_next   = to_reg + 1'b1;

        if (finish) begin
            state_next     = S_DONE;
            res_valid_next = 1'b1;
            res_ref_next   = cnt_ref_next;
            res_sig_next   = cnt_sig_next;
            res_high_next  = cnt_high_next;
            res_ovf_next   = ovf_next;
            res_to_next    = timed_out;
        end
    end

    assign busy         = (state_reg != S_IDLE);
    assign res_valid    = res_valid_reg;
    assign res_cnt_ref  = res_ref_reg;
    assign res_cnt_sig  = res_sig_reg;
    assign res_cnt_high = res_high_reg;
    assign res_ovf      = res_ovf_reg;
    assign res_timeout  = res_to_reg;

endmodule

// File: tb/tb_freq_meter_mc.sv
// Directed bench for freq_meter_mc: a vector table of measurement runs on two
// configurations, plus timeout, handshake-hold and mid-run reset sequences.
module tb_freq_meter_mc;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start0, start1, mode, ready0, ready1;
    logic [1:0] ch_sel, ch_sel_b;
    logic [3:0] sig_in;

    logic        busy0, valid0, ovf0, to0;
    logic [31:0] ref0, sig0, high0;
    logic        busy1, valid1, ovf1, to1;
    logic [7:0]  ref1, sig1, high1;

    freq_meter_mc #(.N_CH(4), .CNT_W(32), .GATE_CYC(1000), .TIMEOUT_CYC(500), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start0), .mode(mode),
        .ch_sel(ch_sel), .ch_sel_b(ch_sel_b), .busy(busy0), .res_valid(valid0),
        .res_ready(ready0), .res_cnt_ref(ref0), .res_cnt_sig(sig0), .res_cnt_high(high0),
        .res_ovf(ovf0), .res_timeout(to0)
    );

    freq_meter_mc #(.N_CH(4), .CNT_W(8), .GATE_CYC(300), .TIMEOUT_CYC(500), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start1), .mode(mode),
        .ch_sel(ch_sel), .ch_sel_b(ch_sel_b), .busy(busy1), .res_valid(valid1),
        .res_ready(ready1), .res_cnt_ref(ref1), .res_cnt_sig(sig1), .res_cnt_high(high1),
        .res_ovf(ovf1), .res_timeout(to1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave generator: channel wa uses (pa,ha,oa), channel wb uses (pb,hb,ob),
    // phases relative to t0; other channels stay low.
    bit wave_en = 1'b0;
    int wa = 0, wb = 0, pa = 10, ha = 5, oa = 0, pb = 10, hb = 5, ob = 0, t0 = 0;

    function automatic bit wave(input int per, input int hi, input int ph);
        if (cyc < t0 + ph) return 1'b0;
        return ((cyc - t0 - ph) % per) < hi;
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (!wave_en)     sig_in[c] = 1'b0;
            else if (c == wa) sig_in[c] = wave(pa, ha, oa);
            else if (c == wb) sig_in[c] = wave(pb, hb, ob);
            else              sig_in[c] = 1'b0;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int     unit;
        bit     m;
        int     a, b;
        int     pa, ha, oa, pb, hb, ob;
        longint e_ref, e_sig, e_high;
        bit     e_ovf, e_to;
    } vec_t;

    vec_t vecs[11];

    task automatic ack(input int unit);
        if (unit == 0) ready0 = 1'b1; else ready1 = 1'b1;
        @(negedge clk);
        ready0 = 1'b0;
        ready1 = 1'b0;
    endtask

    task automatic wait_valid(input int unit, output bit got);
        got = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if ((unit == 0 && valid0) || (unit == 1 && valid1)) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit got;
        longint r, s, h;
        bit o, t;
        wave_en = 1'b0;
        repeat (8) @(negedge clk);
        mode = v.m; ch_sel = 2'(v.a); ch_sel_b = 2'(v.b);
        wa = v.a; wb = v.b;
        pa = v.pa; ha = v.ha; oa = v.oa; pb = v.pb; hb = v.hb; ob = v.ob;
        if (v.unit == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        t0 = cyc + 3;
        wave_en = 1'b1;
        wait_valid(v.unit, got);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL vec%0d_valid: got no res_valid within 5000 cycles, expected res_valid=1", idx);
            return;
        end
        if (v.unit == 0) begin r = ref0; s = sig0; h = high0; o = ovf0; t = to0; end
        else begin r = {24'b0, ref1}; s = {24'b0, sig1}; h = {24'b0, high1}; o = ovf1; t = to1; end
        $display("vec%0d unit=%0d mode=%0d a=%0d b=%0d: ref=%0d sig=%0d high=%0d ovf=%0d to=%0d",
                 idx, v.unit, v.m, v.a, v.b, r, s, h, o, t);
        chk($sformatf("vec%0d_ref", idx), r, v.e_ref);
        chk($sformatf("vec%0d_sig", idx), s, v.e_sig);
        chk($sformatf("vec%0d_high", idx), h, v.e_high);
        chk($sformatf("vec%0d_ovf", idx), longint'(o), longint'(v.e_ovf));
        chk($sformatf("vec%0d_to", idx), longint'(t), longint'(v.e_to));
        ack(v.unit);
    endtask

    initial begin
        bit got;
        bit hold_ok;

        //          unit m  a  b  pa  ha  oa   pb  hb  ob   ref   sig  high ovf to
        vecs[0]  = '{0, 0, 2, 2, 10,  5,  0,  10,  5,  0, 1000, 100, 500, 0, 0};
        vecs[1]  = '{0, 0, 1, 1,  7,  2,  0,   7,  2,  0, 1001, 143, 286, 0, 0};
        vecs[2]  = '{0, 0, 0, 0,  8,  6,  0,   8,  6,  0, 1000, 125, 750, 0, 0};
        vecs[3]  = '{0, 1, 0, 1, 200, 100, 0, 200, 100, 37,  37,   0,   0, 0, 0};
        vecs[4]  = '{0, 1, 0, 1, 200, 100, 0,  50,  25,  0,  50,   0,   0, 0, 0};
        vecs[5]  = '{0, 1, 3, 3, 23,  10,  0,  23,  10,  0,  23,   0,   0, 0, 0};
        vecs[6]  = '{0, 1, 2, 0, 400, 200, 5, 400, 200, 118, 113,  0,   0, 0, 0};
        vecs[7]  = '{1, 0, 2, 2, 20,  10,  0,  20,  10,  0,  255,  15, 150, 1, 0};
        vecs[8]  = '{1, 1, 0, 1, 400, 200, 0, 400, 200, 255, 255,  0,   0, 0, 0};
        vecs[9]  = '{1, 1, 0, 1, 400, 200, 0, 400, 200, 256, 255,  0,   0, 1, 0};
        vecs[10] = '{1, 1, 0, 1, 400, 200, 0, 400, 200, 200, 200,  0,   0, 0, 0};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode = 1'b0;
        ready0 = 1'b0; ready1 = 1'b0; ch_sel = 2'd0; ch_sel_b = 2'd0;
        repeat (3) @(negedge clk);
        $display("reset: busy=%0d valid=%0d ref=%0d", busy0, valid0, ref0);
        chk("reset_busy", longint'(busy0), 0);
        chk("reset_valid", longint'(valid0), 0);
        chk("reset_ref", longint'(ref0), 0);
        chk("reset_busy_u1", longint'(busy1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // Timeout: silent channel, result exactly TIMEOUT_CYC cycles after ARM entry.
        wave_en = 1'b0;
        repeat (8) @(negedge clk);
        mode = 1'b0; ch_sel = 2'd3;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("to_busy_after_start", longint'(busy0), 1);
        repeat (499) @(negedge clk);
        chk("to_valid_at_499", longint'(valid0), 0);
        @(negedge clk);
        $display("timeout: valid=%0d to=%0d ref=%0d ovf=%0d", valid0, to0, ref0, ovf0);
        chk("to_valid_at_500", longint'(valid0), 1);
        chk("to_flag", longint'(to0), 1);
        chk("to_ref", longint'(ref0), 0);
        chk("to_ovf", longint'(ovf0), 0);
        ack(0);

        // Handshake: hold res_ready low while inputs toggle and start pulses.
        wave_en = 1'b0;
        repeat (8) @(negedge clk);
        mode = 1'b0; ch_sel = 2'd2; wa = 2; wb = 2; pa = 10; ha = 5; oa = 0; pb = 10; hb = 5; ob = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t0 = cyc + 3;
        wave_en = 1'b1;
        wait_valid(0, got);
        chk("hs_valid_seen", longint'(got), 1);
        hold_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            start0 = k[0];
            mode = ~k[0];
            ch_sel = 2'(k);
            @(negedge clk);
            if (!(valid0 && busy0 && ref0 == 1000 && sig0 == 100 && high0 == 500 && !ovf0 && !to0))
                hold_ok = 1'b0;
        end
        start0 = 1'b0;
        $display("hold: valid=%0d ref=%0d sig=%0d high=%0d", valid0, ref0, sig0, high0);
        chk("hs_hold_stable", longint'(hold_ok), 1);
        ack(0);
        $display("after ack: valid=%0d busy=%0d", valid0, busy0);
        chk("hs_valid_cleared", longint'(valid0), 0);
        chk("hs_busy_cleared", longint'(busy0), 0);
        mode = 1'b0; ch_sel = 2'd2;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        chk("hs_new_start_busy", longint'(busy0), 1);

        // Reset mid-MEASURE, then a fresh run must match.
        repeat (150) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid reset: busy=%0d valid=%0d ref=%0d sig=%0d high=%0d", busy0, valid0, ref0, sig0, high0);
        chk("rst_busy", longint'(busy0), 0);
        chk("rst_valid", longint'(valid0), 0);
        chk("rst_res_zero", longint'(ref0 | sig0 | high0), 0);
        chk("rst_flags_zero", longint'(ovf0 | to0), 0);
        run_vec(11, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
